// File: rtl/bus_burst_sequencer_if.sv
// Write-side and arbiter/driver-side signals of the burst sequencer.
// slave is the sequencer's view, master is the feeder/arbiter view.
interface bus_burst_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic             bus_req;
  logic             bus_gnt;
  logic [WIDTH-1:0] data_out;
  logic             data_en;
  logic [CW-1:0]    count;
  logic             busy;

  modport master (
    output wr_data,
    output wr_valid,
    output bus_gnt,
    input  wr_ready,
    input  bus_req,
    input  data_out,
    input  data_en,
    input  count,
    input  busy
  );

  modport slave (
    input  wr_data,
    input  wr_valid,
    input  bus_gnt,
    output wr_ready,
    output bus_req,
    output data_out,
    output data_en,
    output count,
    output busy
  );
endinterface

// File: rtl/bus_burst_sequencer.sv
// Buffers write words and streams them as capped bursts once the arbiter
// grants the shared bus, then idles for turnaround before requesting again.
module bus_burst_sequencer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 4,
  parameter int TURN      = 1
) (
  input logic                 clk,
  input logic                 rst,
  bus_burst_sequencer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = (TURN > 1) ? $clog2(TURN) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DRIVE,
    S_TURN
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             req_q;
  logic             req_d;
  logic             en_q;
  logic             en_d;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] dout_d;
  logic [BW-1:0]    beats_q;
  logic [BW-1:0]    beats_d;
  logic [TW-1:0]    tcnt_q;
  logic [TW-1:0]    tcnt_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] head;
  logic             push;
  logic             pop;
  logic             has_data;

  assign bus.wr_ready = (cnt_q < CW'(DEPTH));
  assign push         = bus.wr_valid && bus.wr_ready;
  assign head         = mem[rptr];
  assign has_data     = (cnt_q != '0);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    en_d    = en_q;
    dout_d  = dout_q;
    beats_d = beats_q;
    tcnt_d  = tcnt_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (has_data) begin
          state_d = S_REQ;
          req_d   = 1'b1;
        end
      end
      S_REQ: begin
        if (bus.bus_gnt && has_data) begin
          state_d = S_DRIVE;
          dout_d  = head;
          en_d    = 1'b1;
          pop     = 1'b1;
          beats_d = BW'(1);
        end
      end
      S_DRIVE: begin
        // A dropped grant ends the burst here; the word already
        // on data_out has finished its cycle, nothing is popped.
        if (bus.bus_gnt && has_data &&
            (beats_q < BW'(MAX_BURST))) begin
          dout_d  = head;
          en_d    = 1'b1;
          pop     = 1'b1;
          beats_d = beats_q + BW'(1);
        end else begin
          state_d = S_TURN;
          dout_d  = '0;
          en_d    = 1'b0;
          req_d   = 1'b0;
          tcnt_d  = TW'(TURN - 1);
        end
      end
      S_TURN: begin
        req_d = 1'b0;
        en_d  = 1'b0;
        if (tcnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q - TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        en_d    = 1'b0;
        dout_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      en_q    <= 1'b0;
      dout_q  <= '0;
      beats_q <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      en_q    <= en_d;
      dout_q  <= dout_d;
      beats_q <= beats_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= bus.wr_data;
    end
  end

  assign bus.bus_req  = req_q;
  assign bus.data_en  = en_q;
  assign bus.data_out = dout_q;
  assign bus.count    = cnt_q;
  assign bus.busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_bus_burst_sequencer.sv
// Scoreboard bench: accepted writes queue the expected words, a monitor
// compares every driven word and records burst lengths.
module tb_bus_burst_sequencer;

  logic clk;
  logic rst;

  bus_burst_sequencer_if #(.WIDTH(8), .DEPTH(4)) bif ();

  bus_burst_sequencer #(
    .WIDTH(8),
    .DEPTH(4),
    .MAX_BURST(4),
    .TURN(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  int        checks;
  int        errors;
  logic [7:0] expq[$];
  int        runs[$];
  int        run;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endtask

  task automatic step_push(input logic [7:0] d);
    @(negedge clk);
    bif.wr_data  = d;
    bif.wr_valid = 1'b1;
    if (bif.wr_ready) expq.push_back(d);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((bif.busy || bif.count != 0 || bif.data_en) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_timeout"}, 32'(n < 100), 32'd1);
    check({nm, "_qempty"}, 32'(expq.size()), 32'd0);
  endtask

  task automatic check_runs(input string nm, input int n,
                            input int r0, input int r1);
    check({nm, "_nbursts"}, 32'(runs.size()), 32'(n));
    if (runs.size() > 0) check({nm, "_burst0"}, 32'(runs[0]), 32'(r0));
    if (runs.size() > 1) check({nm, "_burst1"}, 32'(runs[1]), 32'(r1));
    runs.delete();
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    run    = 0;
    clk    = 1'b0;
    rst    = 1'b1;
    bif.wr_data  = '0;
    bif.wr_valid = 1'b0;
    bif.bus_gnt  = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (bif.data_en) begin
          run++;
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_extra got 0x%0h expected none",
                     bif.data_out);
          end else begin
            check("mon_data", 32'(bif.data_out), 32'(expq.pop_front()));
          end
        end else if (run != 0) begin
          runs.push_back(run);
          run = 0;
        end
      end
    join_none

    // reset state
    #3;
    check("rst_count", 32'(bif.count), 32'd0);
    check("rst_req", 32'(bif.bus_req), 32'd0);
    check("rst_en", 32'(bif.data_en), 32'd0);
    check("rst_dout", 32'(bif.data_out), 32'd0);
    check("rst_ready", 32'(bif.wr_ready), 32'd1);
    check("rst_busy", 32'(bif.busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: single word latency
    bif.bus_gnt = 1'b1;
    step_push(8'hA5);
    @(negedge clk);
    bif.wr_valid = 1'b0;
    check("t1_count", 32'(bif.count), 32'd1);
    check("t1_req_e0", 32'(bif.bus_req), 32'd0);
    @(negedge clk);
    check("t1_req_e1", 32'(bif.bus_req), 32'd1);
    check("t1_en_e1", 32'(bif.data_en), 32'd0);
    @(negedge clk);
    check("t1_en_e2", 32'(bif.data_en), 32'd1);
    check("t1_dout_e2", 32'(bif.data_out), 32'hA5);
    @(negedge clk);
    check("t1_en_e3", 32'(bif.data_en), 32'd0);
    check("t1_busy_e3", 32'(bif.busy), 32'd1);
    @(negedge clk);
    check("t1_busy_e4", 32'(bif.busy), 32'd0);
    check_runs("t1", 1, 1, 0);

    // 2: burst cap
    for (int i = 0; i < 6; i++) step_push(8'(i + 1));
    @(negedge clk);
    bif.wr_valid = 1'b0;
    wait_idle("t2");
    check_runs("t2", 2, 4, 2);

    // 3: full FIFO
    bif.bus_gnt = 1'b0;
    for (int i = 0; i < 4; i++) step_push(8'(8'h11 + i));
    @(negedge clk);
    check("t3_ready_full", 32'(bif.wr_ready), 32'd0);
    check("t3_count_full", 32'(bif.count), 32'd4);
    bif.wr_data  = 8'h15;
    bif.wr_valid = 1'b1;
    @(negedge clk);
    bif.wr_valid = 1'b0;
    check("t3_count_rej", 32'(bif.count), 32'd4);
    check("t3_req_wait", 32'(bif.bus_req), 32'd1);
    bif.bus_gnt = 1'b1;
    wait_idle("t3");
    check_runs("t3", 1, 4, 0);

    // 4: grant loss
    bif.bus_gnt = 1'b0;
    for (int i = 0; i < 4; i++) step_push(8'(8'h21 + i));
    @(negedge clk);
    bif.wr_valid = 1'b0;
    check("t4_count_q", 32'(bif.count), 32'd4);
    bif.bus_gnt = 1'b1;
    @(negedge clk);
    check("t4_en_w1", 32'(bif.data_en), 32'd1);
    @(negedge clk);
    check("t4_en_w2", 32'(bif.data_en), 32'd1);
    bif.bus_gnt = 1'b0;
    @(negedge clk);
    check("t4_en_drop", 32'(bif.data_en), 32'd0);
    check("t4_count_drop", 32'(bif.count), 32'd2);
    check("t4_req_drop", 32'(bif.bus_req), 32'd0);
    repeat (3) @(negedge clk);
    check("t4_rereq", 32'(bif.bus_req), 32'd1);
    bif.bus_gnt = 1'b1;
    wait_idle("t4");
    check_runs("t4", 2, 2, 2);

    // 5: async reset mid-burst
    for (int i = 0; i < 3; i++) step_push(8'(8'h31 + i));
    @(negedge clk);
    bif.wr_valid = 1'b0;
    n = 0;
    while (!bif.data_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_drive_seen", 32'(bif.data_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_en_async", 32'(bif.data_en), 32'd0);
    check("t5_req_async", 32'(bif.bus_req), 32'd0);
    check("t5_dout_async", 32'(bif.data_out), 32'd0);
    check("t5_count_async", 32'(bif.count), 32'd0);
    expq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_busy_after", 32'(bif.busy), 32'd0);
    check("t5_req_after", 32'(bif.bus_req), 32'd0);
    check("t5_count_after", 32'(bif.count), 32'd0);
    runs.delete();

    // 6: simultaneous push and pop
    for (int i = 0; i < 6; i++) begin
      step_push(8'(8'h41 + i));
      if (i >= 2) check("t6_count_flow", 32'(bif.count), 32'd2);
    end
    @(negedge clk);
    bif.wr_valid = 1'b0;
    check("t6_count_end", 32'(bif.count), 32'd2);
    check("t6_en_end", 32'(bif.data_en), 32'd1);
    wait_idle("t6");
    check_runs("t6", 2, 4, 2);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
